// File: rtl/sv_uart_pkg.sv
// ---------------------------------------------------------------------------
// sv_uart_pkg
//   Shared definitions for the UART register bridge: command/response opcodes,
//   the bridge FSM state type and a saturating error-counter helper.
// ---------------------------------------------------------------------------
package sv_uart_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W' register write
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R' register read
    localparam logic [7:0] RSP_BAD = 8'h3F;  // '?' unknown command
    localparam logic [7:0] RSP_TMO = 8'h54;  // 'T' read timed out

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } regbridge_state_t;

    // Increment an 8-bit event counter, sticking at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/sv_uart_regbridge.sv
// ---------------------------------------------------------------------------
// sv_uart_regbridge
//   Executes {cmd, addr, data} command frames from the UART engine RX stream
//   as register write/read cycles on a strobe bus and returns one response
//   frame per command into the engine TX stream.
//
// Ports
//   iclk, irst        clock, synchronous active-high reset
//   s_axis_*          command frames in (tready high only while idle)
//   m_axis_*          response frames out
//   oreg_addr/wdata   register address / write data, held until next accept
//   oreg_wr/oreg_rd   one-cycle write / read strobes
//   ireg_rdata/rvalid read return, only observed while waiting for a read
//   oerr_cnt          saturating count of bad commands and read timeouts
// ---------------------------------------------------------------------------
module sv_uart_regbridge
    import sv_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH-1:0] oreg_addr,
    output logic [REG_WIDTH-1:0]  oreg_wdata,
    output logic                  oreg_wr,
    output logic                  oreg_rd,
    input  logic [REG_WIDTH-1:0]  ireg_rdata,
    input  logic                  ireg_rvalid,
    output logic [7:0]            oerr_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // Timer value in the last WAIT_RD cycle that still accepts read data.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    if (DATA_WIDTH != 8 + ADDR_WIDTH + REG_WIDTH) begin : g_bad_width
        $error("sv_uart_regbridge: DATA_WIDTH must equal 8 + ADDR_WIDTH + REG_WIDTH");
    end

    regbridge_state_t      state_q, state_d;
    logic                  tready_q, tready_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [7:0]            err_q, err_d;
    logic [7:0]            in_cmd_s;

    assign in_cmd_s = s_axis_tdata[DATA_WIDTH-1 -: 8];

    // Next-state, response and strobe computation for the command FSM.
    always_comb begin
        state_d = state_q;
        tdata_d = tdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cmd_d   = cmd_q;
        timer_d = timer_q;
        err_d   = err_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_axis_tvalid && tready_q) begin
                    cmd_d   = in_cmd_s;
                    addr_d  = s_axis_tdata[DATA_WIDTH-9 -: ADDR_WIDTH];
                    wdata_d = s_axis_tdata[REG_WIDTH-1:0];
                    // Strobes are registered, so they are decided here and
                    // appear during the EXEC cycle.
                    wr_d    = (in_cmd_s == CMD_WR);
                    rd_d    = (in_cmd_s == CMD_RD);
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cmd_q == CMD_WR) begin
                    tdata_d = {CMD_WR, addr_q, wdata_q};
                    state_d = RESP;
                end else if (cmd_q == CMD_RD) begin
                    timer_d = {TW{1'b0}};
                    state_d = WAIT_RD;
                end else begin
                    tdata_d = {RSP_BAD, addr_q, {REG_WIDTH{1'b0}}};
                    err_d   = sat_inc8(err_q);
                    state_d = RESP;
                end
            end
            WAIT_RD: begin
                // Read data takes priority over a timeout in the same cycle.
                if (ireg_rvalid) begin
                    tdata_d = {CMD_RD, addr_q, ireg_rdata};
                    state_d = RESP;
                end else if (timer_q == TMO_LAST) begin
                    tdata_d = {RSP_TMO, addr_q, {REG_WIDTH{1'b0}}};
                    err_d   = sat_inc8(err_q);
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (m_axis_tready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tready_d = (state_d == IDLE);
        tvalid_d = (state_d == RESP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= IDLE;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= {DATA_WIDTH{1'b0}};
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= {ADDR_WIDTH{1'b0}};
            wdata_q  <= {REG_WIDTH{1'b0}};
            cmd_q    <= 8'h00;
            timer_q  <= {TW{1'b0}};
            err_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cmd_q    <= cmd_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign oreg_wr       = wr_q;
    assign oreg_rd       = rd_q;
    assign oreg_addr     = addr_q;
    assign oreg_wdata    = wdata_q;
    assign oerr_cnt      = err_q;

endmodule

// File: tb/tb_sv_uart_regbridge.sv
// ---------------------------------------------------------------------------
// tb_sv_uart_regbridge
//   Self-checking bench for sv_uart_regbridge (TIMEOUT=16). Inputs are driven
//   and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sv_uart_regbridge;

    localparam int TMO = 16;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic [23:0] s_axis_tdata = 24'h0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [7:0]  oreg_addr;
    logic [7:0]  oreg_wdata;
    logic        oreg_wr;
    logic        oreg_rd;
    logic [7:0]  ireg_rdata = 8'h0;
    logic        ireg_rvalid = 1'b0;
    logic [7:0]  oerr_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int err_model = 0;

    sv_uart_regbridge #(
        .DATA_WIDTH(24), .ADDR_WIDTH(8), .REG_WIDTH(8), .TIMEOUT(TMO)
    ) dut (
        .iclk(iclk), .irst(irst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .oreg_addr(oreg_addr), .oreg_wdata(oreg_wdata), .oreg_wr(oreg_wr), .oreg_rd(oreg_rd),
        .ireg_rdata(ireg_rdata), .ireg_rvalid(ireg_rvalid), .oerr_cnt(oerr_cnt)
    );

    always #5 iclk = ~iclk;

    // One full command: drive the frame, play the register-side model, apply
    // backpressure and check every cycle until the response handshake.
    // rv_delay: cycles after oreg_rd at which rvalid pulses (-1 = never).
    task automatic do_cmd(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                          input int rv_delay, input logic [7:0] rdata, input int hold, input bit junk);
        logic [23:0] exp_resp;
        int          r_cyc;
        int          c;
        bit          done;
        bit          exp_v;
        // Reference: what the command should return and when.
        if (cmd == 8'h57) begin
            exp_resp = {8'h57, addr, data};
            r_cyc = 2;
        end else if (cmd == 8'h52) begin
            if (rv_delay >= 1 && rv_delay <= TMO) begin
                exp_resp = {8'h52, addr, rdata};
                r_cyc = 2 + rv_delay;
            end else begin
                exp_resp = {8'h54, addr, 8'h00};
                r_cyc = 2 + TMO;
                err_model = (err_model + 1 > 255) ? 255 : err_model + 1;
            end
        end else begin
            exp_resp = {8'h3F, addr, 8'h00};
            r_cyc = 2;
            err_model = (err_model + 1 > 255) ? 255 : err_model + 1;
        end

        @(negedge iclk);
        tests_run++;
        if (s_axis_tready !== 1'b1) begin tests_failed++; $display("FAIL idle_tready got=%b want=1", s_axis_tready); end
        s_axis_tdata = {cmd, addr, data};
        s_axis_tvalid = 1'b1;
        @(negedge iclk);
        s_axis_tvalid = junk;
        if (junk) s_axis_tdata = {8'h57, 8'($urandom), 8'($urandom)};
        c = 1;
        done = 1'b0;
        while (!done && c < 100) begin
            ireg_rvalid = (rv_delay >= 0 && c == 1 + rv_delay);
            ireg_rdata = ireg_rvalid ? rdata : 8'($urandom);
            m_axis_tready = !(c >= r_cyc && c < r_cyc + hold);
            exp_v = (c >= r_cyc);
            tests_run++;
            if (oreg_wr !== (c == 1 && cmd == 8'h57)) begin tests_failed++; $display("FAIL wr_strobe c=%0d got=%b", c, oreg_wr); end
            tests_run++;
            if (oreg_rd !== (c == 1 && cmd == 8'h52)) begin tests_failed++; $display("FAIL rd_strobe c=%0d got=%b", c, oreg_rd); end
            tests_run++;
            if (oreg_addr !== addr || oreg_wdata !== data) begin tests_failed++; $display("FAIL reg_bus c=%0d got=%h/%h want=%h/%h", c, oreg_addr, oreg_wdata, addr, data); end
            tests_run++;
            if (m_axis_tvalid !== exp_v) begin tests_failed++; $display("FAIL tvalid c=%0d got=%b want=%b", c, m_axis_tvalid, exp_v); end
            tests_run++;
            if (s_axis_tready !== 1'b0) begin tests_failed++; $display("FAIL busy_tready c=%0d got=%b want=0", c, s_axis_tready); end
            if (exp_v) begin
                tests_run++;
                if (m_axis_tdata !== exp_resp) begin tests_failed++; $display("FAIL resp_data c=%0d got=%h want=%h", c, m_axis_tdata, exp_resp); end
            end
            if (exp_v && m_axis_tready) done = 1'b1;
            @(negedge iclk);
            c++;
        end
        s_axis_tvalid = 1'b0;
        ireg_rvalid = 1'b0;
        m_axis_tready = 1'b1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin tests_failed++; $display("FAIL post_hs got tvalid=%b tready=%b want 0/1", m_axis_tvalid, s_axis_tready); end
        tests_run++;
        if (oerr_cnt !== 8'(err_model)) begin tests_failed++; $display("FAIL err_cnt got=%0d want=%0d", oerr_cnt, err_model); end
    endtask

    task automatic test_reset();
        irst = 1'b1;
        repeat (3) @(negedge iclk);
        tests_run++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 24'h0 ||
            oreg_wr !== 1'b0 || oreg_rd !== 1'b0 || oreg_addr !== 8'h0 || oreg_wdata !== 8'h0 || oerr_cnt !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_vals got tready=%b tvalid=%b tdata=%h wr=%b rd=%b addr=%h wdata=%h err=%h want all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, oreg_wr, oreg_rd, oreg_addr, oreg_wdata, oerr_cnt);
        end
        irst = 1'b0;
        err_model = 0;
        @(negedge iclk);
        tests_run++;
        if (s_axis_tready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_tready got=%b want=1", s_axis_tready); end
    endtask

    task automatic test_write();
        do_cmd(8'h57, 8'h10, 8'hA5, -1, 8'h00, 0, 1'b0);
    endtask

    task automatic test_read();
        do_cmd(8'h52, 8'h22, 8'h00, 3, 8'h3C, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_cmd(8'h52, 8'h22, 8'h00, -1, 8'h00, 0, 1'b0);
        // Late read data in IDLE must not create a response.
        ireg_rvalid = 1'b1;
        ireg_rdata = 8'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge iclk);
            tests_run++;
            if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin tests_failed++; $display("FAIL late_rvalid got tvalid=%b tready=%b want 0/1", m_axis_tvalid, s_axis_tready); end
        end
        ireg_rvalid = 1'b0;
        // rvalid coincident with oreg_rd is ignored, and rvalid on the last waiting cycle wins.
        do_cmd(8'h52, 8'h23, 8'h00, 0, 8'h11, 0, 1'b0);
        do_cmd(8'h52, 8'h24, 8'h00, TMO, 8'h5A, 0, 1'b0);
        do_cmd(8'h52, 8'h25, 8'h00, TMO + 1, 8'h5B, 0, 1'b0);
    endtask

    task automatic test_bad_cmd();
        do_cmd(8'h41, 8'h05, 8'h77, -1, 8'h00, 0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            do_cmd(8'h41, 8'($urandom), 8'($urandom), -1, 8'h00, 0, 1'b0);
        end
        tests_run++;
        if (oerr_cnt !== 8'hFF) begin tests_failed++; $display("FAIL err_saturate got=%h want=ff", oerr_cnt); end
    endtask

    task automatic test_backpressure();
        do_cmd(8'h57, 8'h30, 8'h12, -1, 8'h00, 20, 1'b1);
        do_cmd(8'h57, 8'h31, 8'h34, -1, 8'h00, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] cmd;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(2, 0))
                0: cmd = 8'h57;
                1: cmd = 8'h52;
                default: begin
                    cmd = 8'($urandom);
                    while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
                end
            endcase
            do_cmd(cmd, 8'($urandom), 8'($urandom), $urandom_range(TMO + 2, 0) - 1,
                   8'($urandom), $urandom_range(3, 0), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        // Reset while waiting for read data.
        @(negedge iclk);
        s_axis_tdata = 24'h52_33_00;
        s_axis_tvalid = 1'b1;
        @(negedge iclk);
        s_axis_tvalid = 1'b0;
        repeat (4) @(negedge iclk);
        irst = 1'b1;
        @(negedge iclk);
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || oreg_rd !== 1'b0 || oerr_cnt !== 8'h0 || s_axis_tready !== 1'b0) begin
            tests_failed++; $display("FAIL rst_waitrd got tvalid=%b rd=%b err=%h tready=%b want 0/0/00/0", m_axis_tvalid, oreg_rd, oerr_cnt, s_axis_tready);
        end
        irst = 1'b0;
        err_model = 0;
        @(negedge iclk);
        tests_run++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_waitrd_idle got tready=%b tvalid=%b want 1/0", s_axis_tready, m_axis_tvalid); end
        // Reset while a response is stalled.
        do_cmd(8'h00, 8'h01, 8'h02, -1, 8'h00, 0, 1'b0);
        m_axis_tready = 1'b0;
        @(negedge iclk);
        s_axis_tdata = 24'h57_44_55;
        s_axis_tvalid = 1'b1;
        @(negedge iclk);
        s_axis_tvalid = 1'b0;
        repeat (3) @(negedge iclk);
        tests_run++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h57_44_55) begin tests_failed++; $display("FAIL resp_stalled got tvalid=%b tdata=%h want 1/574455", m_axis_tvalid, m_axis_tdata); end
        irst = 1'b1;
        @(negedge iclk);
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || oreg_wr !== 1'b0 || oerr_cnt !== 8'h0) begin
            tests_failed++; $display("FAIL rst_resp got tvalid=%b wr=%b err=%h want 0/0/00", m_axis_tvalid, oreg_wr, oerr_cnt);
        end
        irst = 1'b0;
        m_axis_tready = 1'b1;
        err_model = 0;
        @(negedge iclk);
        tests_run++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_resp_idle got tready=%b tvalid=%b want 1/0", s_axis_tready, m_axis_tvalid); end
        do_cmd(8'h57, 8'h66, 8'h77, -1, 8'h00, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_backpressure();
        test_random();
        test_bad_cmd();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
